rs_error_corrector: RTL and testbench

- Final stage of the RS(255,239) decoder, directly downstream of Chien search and the Forney magnitude unit.
- Holds each received codeword in a two-bank ping-pong symbol buffer while syndrome calculation, Berlekamp-Massey and Chien search run on it.
- Replays the codeword in lock-step with the per-symbol error flag/magnitude stream, XORing in the magnitude at flagged positions.
- Emits corrected symbols with framing plus per-frame error count and decode-failure status.

---
 rtl/rs_error_corrector_if.sv | 36 +++
 rtl/rs_error_corrector.sv | 170 +++++++++++++++++
 tb/tb_rs_error_corrector.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_error_corrector_if.sv
// Symbol-stream bus for the RS(255,239) error corrector: received symbols and
// Chien/Forney stream in, corrected symbols and per-frame status out.
interface rs_error_corrector_if #(
    parameter int unsigned M = 8
);
    logic         data_in_valid;
    logic         data_in_sop;
    logic [M-1:0] data_in;
    logic         corr_start;
    logic         Error_symbol;
    logic [M-1:0] Error_value;
    logic [3:0]   Lambda_degree;
    logic         data_out_valid;
    logic         data_out_sop;
    logic         data_out_eop;
    logic         data_out_msg;
    logic [M-1:0] data_out;
    logic [3:0]   err_count;
    logic         decode_fail;
    logic         status_valid;
    logic         overrun;

    modport slave (
        input  data_in_valid, data_in_sop, data_in, corr_start, Error_symbol, Error_value,
        input  Lambda_degree,
        output data_out_valid, data_out_sop, data_out_eop, data_out_msg, data_out,
        output err_count, decode_fail, status_valid, overrun
    );

    modport master (
        output data_in_valid, data_in_sop, data_in, corr_start, Error_symbol, Error_value,
        output Lambda_degree,
        input  data_out_valid, data_out_sop, data_out_eop, data_out_msg, data_out,
        input  err_count, decode_fail, status_valid, overrun
    );
endinterface

// File: rtl/rs_error_corrector.sv
// RS(255,239) final stage: ping-pong codeword buffer replayed in lock-step with the
// Chien/Forney error stream, XORing magnitudes into flagged symbols.
module rs_error_corrector #(
    parameter int unsigned N = 255,
    parameter int unsigned K = 239,
    parameter int unsigned T = 8,
    parameter int unsigned M = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    rs_error_corrector_if.slave    bus
);
    localparam int unsigned AW = $clog2(2 * N);
    localparam int unsigned IW = $clog2(N);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CORRECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_STATUS  = 2'd3;

    logic [M-1:0]  r_mem [0:2*N-1];
    logic [M-1:0]  r_ram_q;
    logic          r_wr_bank;
    logic [IW-1:0] r_wr_idx;
    logic [1:0]    r_bank_full;
    logic          r_overrun;
    logic [1:0]    r_state;
    logic          r_rd_bank;
    logic [IW-1:0] r_rd_idx;
    logic [3:0]    r_errcnt;
    logic [3:0]    r_lambda;
    logic          r_v1;
    logic          r_err1;
    logic [M-1:0]  r_val1;
    logic [IW-1:0] r_j1;
    logic          r_out_valid;
    logic          r_out_sop;
    logic          r_out_eop;
    logic          r_out_msg;
    logic [M-1:0]  r_data_out;
    logic [3:0]    r_err_count;
    logic          r_decode_fail;
    logic          r_status_valid;

    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic          w_wr_last;
    logic [AW-1:0] w_wr_addr;
    logic          w_accept;
    logic          w_rd_en;
    logic [IW-1:0] w_rd_j;
    logic [AW-1:0] w_rd_addr;
    logic [1:0]    w_full_d;

    assign w_wr_en   = bus.data_in_valid;
    assign w_wr_idx  = bus.data_in_sop ? '0 : r_wr_idx;
    assign w_wr_last = w_wr_en && (w_wr_idx == IW'(N - 1));
    assign w_wr_addr = (r_wr_bank ? AW'(N) : AW'(0)) + AW'(w_wr_idx);

    // Symbol 0 is read in the corr_start cycle itself so data meets its flag one cycle later.
    assign w_accept  = (r_state == S_IDLE) && bus.corr_start && r_bank_full[r_rd_bank];
    assign w_rd_en   = w_accept || (r_state == S_CORRECT);
    assign w_rd_j    = (r_state == S_CORRECT) ? r_rd_idx : '0;
    assign w_rd_addr = (r_rd_bank ? AW'(N) : AW'(0)) + AW'(w_rd_j);

    always_comb begin
        w_full_d = r_bank_full;
        if (r_state == S_STATUS) w_full_d[r_rd_bank] = 1'b0;
        if (w_wr_last)           w_full_d[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_en) r_mem[w_wr_addr] <= bus.data_in;
        if (w_rd_en) r_ram_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_bank_full <= 2'b00;
            r_overrun   <= 1'b0;
        end else begin
            r_bank_full <= w_full_d;
            if (w_wr_en) begin
                if (r_bank_full[r_wr_bank]) r_overrun <= 1'b1;
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= w_wr_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_bank <= 1'b0;
            r_rd_idx  <= '0;
            r_lambda  <= '0;
            r_errcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_CORRECT;
                        r_rd_idx <= IW'(1);
                        r_lambda <= bus.Lambda_degree;
                        r_errcnt <= {3'b000, bus.Error_symbol};
                    end
                end
                S_CORRECT: begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                    if (bus.Error_symbol && (r_errcnt != 4'hF)) r_errcnt <= r_errcnt + 1'b1;
                    if (r_rd_idx == IW'(N - 1)) r_state <= S_DRAIN;
                end
                S_DRAIN: r_state <= S_STATUS;
                S_STATUS: begin
                    r_rd_bank <= ~r_rd_bank;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_v1           <= 1'b0;
            r_err1         <= 1'b0;
            r_val1         <= '0;
            r_j1           <= '0;
            r_out_valid    <= 1'b0;
            r_out_sop      <= 1'b0;
            r_out_eop      <= 1'b0;
            r_out_msg      <= 1'b0;
            r_data_out     <= '0;
            r_err_count    <= '0;
            r_decode_fail  <= 1'b0;
            r_status_valid <= 1'b0;
        end else begin
            r_v1           <= w_rd_en;
            r_err1         <= w_rd_en && bus.Error_symbol;
            r_val1         <= bus.Error_value;
            r_j1           <= w_rd_j;
            r_out_valid    <= r_v1;
            r_out_sop      <= r_v1 && (r_j1 == '0);
            r_out_eop      <= r_v1 && (r_j1 == IW'(N - 1));
            r_out_msg      <= r_v1 && (r_j1 < IW'(K));
            r_data_out     <= r_ram_q ^ (r_err1 ? r_val1 : '0);
            r_status_valid <= (r_state == S_DRAIN);
            if (r_state == S_DRAIN) begin
                r_err_count   <= r_errcnt;
                r_decode_fail <= (r_errcnt != r_lambda) || (r_lambda > 4'(T));
            end
        end
    end

    assign bus.data_out_valid = r_out_valid;
    assign bus.data_out_sop   = r_out_sop;
    assign bus.data_out_eop   = r_out_eop;
    assign bus.data_out_msg   = r_out_msg;
    assign bus.data_out       = r_data_out;
    assign bus.err_count      = r_err_count;
    assign bus.decode_fail    = r_decode_fail;
    assign bus.status_valid   = r_status_valid;
    assign bus.overrun        = r_overrun;
endmodule

// File: tb/tb_rs_error_corrector.sv
// Directed bench for rs_error_corrector: symbol replay, correction, status, ping-pong,
// overrun, framing restart and asynchronous reset.
module tb_rs_error_corrector;
    localparam int N = 255;
    localparam int K = 239;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    rs_error_corrector_if bus ();

    rs_error_corrector dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk_in) cyc++;

    logic [7:0] cap_d   [4096];
    logic       cap_sop [4096];
    logic       cap_eop [4096];
    logic       cap_msg [4096];
    int         cap_cyc [4096];
    int         cap_n   = 0;
    int         st_n    = 0;
    int         st_cyc  = 0;
    logic [3:0] st_err;
    logic       st_fail;

    always @(negedge clk_in) begin
        if (bus.data_out_valid === 1'b1 && cap_n < 4096) begin
            cap_d[cap_n]   = bus.data_out;
            cap_sop[cap_n] = bus.data_out_sop;
            cap_eop[cap_n] = bus.data_out_eop;
            cap_msg[cap_n] = bus.data_out_msg;
            cap_cyc[cap_n] = cyc;
            cap_n++;
        end
        if (bus.status_valid === 1'b1) begin
            st_n++;
            st_cyc  = cyc;
            st_err  = bus.err_count;
            st_fail = bus.decode_fail;
        end
    end

    bit         e_flag [N];
    logic [7:0] e_val  [N];
    int         cs_cyc = 0;
    int         g_base = 0;
    int         g_st   = 0;

    task automatic clear_errs();
        for (int j = 0; j < N; j++) begin
            e_flag[j] = 1'b0;
            e_val[j]  = 8'h00;
        end
    endtask

    task automatic write_frame(input int seed, input int count);
        for (int j = 0; j < count; j++) begin
            @(posedge clk_in); #1;
            bus.data_in_valid = 1'b1;
            bus.data_in_sop   = (j == 0);
            bus.data_in       = 8'(j + seed);
        end
        @(posedge clk_in); #1;
        bus.data_in_valid = 1'b0;
        bus.data_in_sop   = 1'b0;
    endtask

    task automatic drive_corr(input logic [3:0] lam);
        g_base = cap_n;
        g_st   = st_n;
        for (int j = 0; j < N; j++) begin
            @(posedge clk_in); #1;
            if (j == 0) cs_cyc = cyc;
            bus.corr_start    = (j == 0);
            bus.Lambda_degree = lam;
            bus.Error_symbol  = e_flag[j];
            bus.Error_value   = e_val[j];
        end
        @(posedge clk_in); #1;
        bus.corr_start   = 1'b0;
        bus.Error_symbol = 1'b0;
        bus.Error_value  = 8'h00;
    endtask

    task automatic check_frame(input string name, input int seed, input int exp_err,
                               input bit exp_fail);
        int w, bad, fj;
        logic [7:0] exp_d, fa, fe;
        w = 0;
        while ((cap_n < g_base + N || st_n == g_st) && w < 1000) begin
            @(posedge clk_in);
            w++;
        end
        checks++;
        if (w >= 1000) begin
            failures++;
            $display("FAIL %s_timeout: outputs=%0d status=%0d required outputs=%0d status=1",
                     name, cap_n - g_base, st_n - g_st, N);
            return;
        end
        repeat (4) @(posedge clk_in);
        checks++;
        if (cap_n - g_base != N) begin
            failures++;
            $display("FAIL %s_count: got %0d valid cycles, expected %0d", name, cap_n - g_base, N);
        end
        bad = 0; fj = 0; fa = 0; fe = 0;
        for (int j = 0; j < N; j++) begin
            exp_d = 8'(j + seed) ^ (e_flag[j] ? e_val[j] : 8'h00);
            if (cap_d[g_base + j] !== exp_d) begin
                if (bad == 0) begin fj = j; fa = cap_d[g_base + j]; fe = exp_d; end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_data: %0d bad symbols, first j=%0d got %h expected %h",
                     name, bad, fj, fa, fe);
        end
        bad = 0; fj = 0;
        for (int j = 0; j < N; j++) begin
            if (cap_sop[g_base + j] !== (j == 0) || cap_eop[g_base + j] !== (j == N - 1) ||
                cap_msg[g_base + j] !== (j < K)) begin
                if (bad == 0) fj = j;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_framing: %0d bad sop/eop/msg, first j=%0d sop=%b eop=%b msg=%b",
                     name, bad, fj, cap_sop[g_base + fj], cap_eop[g_base + fj],
                     cap_msg[g_base + fj]);
        end
        bad = 0;
        for (int j = 0; j < N; j++) if (cap_cyc[g_base + j] != cs_cyc + j + 2) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s_latency: first output at cycle %0d, expected %0d (%0d off)",
                     name, cap_cyc[g_base] - cs_cyc, 2, bad);
        end
        checks++;
        if (st_n - g_st != 1 || st_cyc != cs_cyc + N + 1) begin
            failures++;
            $display("FAIL %s_status_pulse: pulses=%0d at +%0d, expected 1 at +%0d",
                     name, st_n - g_st, st_cyc - cs_cyc, N + 1);
        end
        checks++;
        if (st_err !== 4'(exp_err) || st_fail !== exp_fail) begin
            failures++;
            $display("FAIL %s_status: err_count=%0d decode_fail=%b, expected %0d %b",
                     name, st_err, st_fail, exp_err, exp_fail);
        end
    endtask

    task automatic test_reset();
        logic [18:0] outs;
        bus.data_in_valid = 0; bus.data_in_sop = 0; bus.data_in = 0; bus.corr_start = 0;
        bus.Error_symbol = 0; bus.Error_value = 0; bus.Lambda_degree = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        outs = {bus.data_out_valid, bus.data_out_sop, bus.data_out_eop, bus.data_out_msg,
                bus.status_valid, bus.decode_fail, bus.overrun, bus.err_count, bus.data_out};
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_zero_error();
        clear_errs();
        write_frame(0, N);
        drive_corr(4'd0);
        check_frame("zero_err", 0, 0, 1'b0);
    endtask

    task automatic test_three_errors();
        clear_errs();
        e_flag[5] = 1; e_val[5] = 8'h1F;
        e_flag[100] = 1; e_val[100] = 8'h80;
        e_flag[250] = 1; e_val[250] = 8'hFF;
        write_frame(0, N);
        drive_corr(4'd3);
        check_frame("three_err", 0, 3, 1'b0);
        checks++;
        if (cap_d[g_base + 5] !== 8'h1A || cap_d[g_base + 100] !== 8'hE4 ||
            cap_d[g_base + 250] !== 8'h05 || cap_d[g_base + 6] !== 8'h06) begin
            failures++;
            $display("FAIL three_err_symbols: got %h %h %h %h expected 1a e4 05 06",
                     cap_d[g_base + 5], cap_d[g_base + 100], cap_d[g_base + 250],
                     cap_d[g_base + 6]);
        end
    endtask

    task automatic test_mismatch();
        clear_errs();
        e_flag[10] = 1; e_val[10] = 8'h01;
        e_flag[20] = 1; e_val[20] = 8'h02;
        write_frame(3, N);
        drive_corr(4'd3);
        check_frame("two_flags_l3", 3, 2, 1'b1);
        clear_errs();
        for (int i = 0; i < 9; i++) begin e_flag[i * 20] = 1; e_val[i * 20] = 8'(i + 1); end
        write_frame(4, N);
        drive_corr(4'd9);
        check_frame("nine_flags_l9", 4, 9, 1'b1);
        clear_errs();
        for (int i = 0; i < 8; i++) begin e_flag[i * 30 + 1] = 1; e_val[i * 30 + 1] = 8'h55; end
        write_frame(9, N);
        drive_corr(4'd8);
        check_frame("eight_flags_l8", 9, 8, 1'b0);
        clear_errs();
        for (int i = 0; i < 16; i++) begin e_flag[i * 15] = 1; e_val[i * 15] = 8'hA0; end
        write_frame(11, N);
        drive_corr(4'd15);
        check_frame("sixteen_flags_sat", 11, 15, 1'b1);
    endtask

    task automatic test_back_to_back();
        clear_errs();
        write_frame(17, N);
        fork
            write_frame(33, N);
            drive_corr(4'd0);
        join
        check_frame("pingpong_a", 17, 0, 1'b0);
        drive_corr(4'd0);
        check_frame("pingpong_b", 33, 0, 1'b0);
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL pingpong_overrun: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_overrun();
        write_frame(1, N);
        write_frame(2, N);
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_two_frames: got %b expected 0", bus.overrun);
        end
        write_frame(3, N);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_third_frame: got %b expected 1", bus.overrun);
        end
        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b expected 1", bus.overrun);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_reset: got %b expected 0", bus.overrun);
        end
        @(posedge clk_in); #1 rst_n = 1'b1;
    endtask

    task automatic test_framing();
        int base, st0;
        clear_errs();
        write_frame(50, 100);
        write_frame(7, N);
        drive_corr(4'd0);
        check_frame("sop_restart", 7, 0, 1'b0);
        base = cap_n;
        st0  = st_n;
        @(posedge clk_in); #1 bus.corr_start = 1'b1;
        @(posedge clk_in); #1 bus.corr_start = 1'b0;
        repeat (300) @(posedge clk_in);
        checks++;
        if (cap_n != base || st_n != st0) begin
            failures++;
            $display("FAIL empty_corr_start: outputs=%0d status=%0d expected 0 0",
                     cap_n - base, st_n - st0);
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] outs;
        clear_errs();
        write_frame(5, N);
        @(posedge clk_in); #1 bus.corr_start = 1'b1;
        @(posedge clk_in); #1 bus.corr_start = 1'b0;
        repeat (50) @(posedge clk_in);
        #3;
        checks++;
        if (bus.data_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_correct_active: valid=%b expected 1", bus.data_out_valid);
        end
        rst_n = 1'b0;
        #1;
        outs = {bus.data_out_valid, bus.data_out_sop, bus.data_out_eop, bus.data_out_msg,
                bus.status_valid, bus.decode_fail, bus.overrun, bus.err_count, bus.data_out};
        checks++;
        if (outs !== 19'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected 0", outs);
        end
        @(posedge clk_in); #1 rst_n = 1'b1;
        write_frame(99, N);
        drive_corr(4'd0);
        check_frame("after_reset", 99, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_error();
        test_three_errors();
        test_mismatch();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
